// File: rtl/s2p_receiver_pkg.sv
// Shared types and default sizing for the serial-to-parallel link receiver.
package s2p_receiver_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } state_t;

  localparam int DEFAULT_DATA_BITS       = 64;
  localparam int DEFAULT_DATA_COUNT_BITS = 6;

endpackage

// File: rtl/s2p_receiver_sync_edge.sv
// Two-flop synchronizer with an extra delay flop for rising-edge detection.
module sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic level_s,
  output logic rise
);

  logic [1:0] sync_r;
  logic       dly_r;

  // synchronizer chain plus one-cycle delay of the synchronized level
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_r <= 2'b00;
      dly_r  <= 1'b0;
    end else begin
      sync_r <= {sync_r[0], d};
      dly_r  <= sync_r[1];
    end
  end

  assign level_s = sync_r[1];
  assign rise    = sync_r[1] & ~dly_r;

endmodule

// File: rtl/s2p_receiver.sv
// Reassembles serial link frames into DATA_BITS-wide words in the clk domain,
// handing them to the consumer through a valid/ack handshake with sticky overrun.
module s2p_receiver
  import s2p_receiver_pkg::*;
#(
  parameter int DATA_BITS       = DEFAULT_DATA_BITS,
  parameter int DATA_COUNT_BITS = DEFAULT_DATA_COUNT_BITS,
  parameter bit DIR             = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sclk,
  input  logic                 sclrn,
  input  logic                 sin,
  input  logic                 Ack,
  output logic [DATA_BITS-1:0] PData,
  output logic                 Valid,
  output logic                 Overrun,
  output logic                 Busy
);

  localparam logic [DATA_COUNT_BITS-1:0] LAST_CNT = DATA_COUNT_BITS'(DATA_BITS - 1);

  logic                       sclk_s;
  logic                       rise;
  logic [1:0]                 sclrn_sync_r;
  logic [1:0]                 sin_sync_r;
  logic                       sclrn_s;
  logic                       sin_s;
  logic                       take_bit;
  logic [DATA_BITS-1:0]       sr_r;
  logic [DATA_BITS-1:0]       sr_next;
  logic [DATA_COUNT_BITS-1:0] cnt_r;
  state_t                     state_r;

  // Shift-based form keeps DATA_BITS=1 legal (no negative part-selects).
  function automatic logic [DATA_BITS-1:0] shift_in(input logic [DATA_BITS-1:0] word,
                                                    input logic b);
    if (DIR) begin
      return (word >> 1) | (DATA_BITS'(b) << (DATA_BITS - 1));
    end else begin
      return (word << 1) | DATA_BITS'(b);
    end
  endfunction

  sync_edge u_sclk_sync (
    .clk     (clk),
    .rst     (rst),
    .d       (sclk),
    .level_s (sclk_s),
    .rise    (rise)
  );

  // level-only synchronizers for frame clear and serial data
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sclrn_sync_r <= 2'b00;
      sin_sync_r   <= 2'b00;
    end else begin
      sclrn_sync_r <= {sclrn_sync_r[0], sclrn};
      sin_sync_r   <= {sin_sync_r[0], sin};
    end
  end

  assign sclrn_s  = sclrn_sync_r[1];
  assign sin_s    = sin_sync_r[1];
  assign take_bit = rise & sclk_s;
  assign sr_next  = shift_in(sr_r, sin_s);

  // frame FSM, shift register, bit counter and handshake output register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
      cnt_r   <= {DATA_COUNT_BITS{1'b0}};
      sr_r    <= {DATA_BITS{1'b0}};
      PData   <= {DATA_BITS{1'b0}};
      Valid   <= 1'b0;
      Overrun <= 1'b0;
      Busy    <= 1'b0;
    end else begin
      if (Ack) begin
        Valid   <= 1'b0;
        Overrun <= 1'b0;
      end
      if (!sclrn_s) begin
        state_r <= IDLE;
        cnt_r   <= {DATA_COUNT_BITS{1'b0}};
        sr_r    <= {DATA_BITS{1'b0}};
        Busy    <= 1'b0;
      end else if (take_bit) begin
        sr_r <= sr_next;
        if ((state_r == RECV && cnt_r == LAST_CNT) || DATA_BITS == 1) begin
          state_r <= IDLE;
          cnt_r   <= {DATA_COUNT_BITS{1'b0}};
          Busy    <= 1'b0;
          // A same-cycle Ack frees the output register for the new word.
          if (!Valid || Ack) begin
            PData <= sr_next;
            Valid <= 1'b1;
          end else begin
            Overrun <= 1'b1;
          end
        end else begin
          case (state_r)
            IDLE: begin
              state_r <= RECV;
              cnt_r   <= DATA_COUNT_BITS'(1);
              Busy    <= 1'b1;
            end
            RECV: begin
              cnt_r <= cnt_r + DATA_COUNT_BITS'(1);
            end
            default: begin
              state_r <= IDLE;
              cnt_r   <= {DATA_COUNT_BITS{1'b0}};
              Busy    <= 1'b0;
            end
          endcase
        end
      end
    end
  end

endmodule
